// File: rtl/audio_fx_pipe.sv
// audio_fx_pipe -- two-stage audio effect pipeline between codec in/out FIFOs.
//   S1 attenuates each channel by an arithmetic right shift (SW[3:1]).
//   S2 multiplies by the mute gain, rescales and saturates into audio_out.
//
// Ports:
//   CLOCK_50           sole clock, rising edge
//   resetn             asynchronous active-low reset
//   SW[0]              mute, SW[3:1] attenuation shift, SW[9:4] unused
//   audio_in_available codec has an input frame
//   audio_out_allowed  codec can accept an output frame
//   read_audio_in      combinational: input frame consumed this cycle
//   write_audio_out    combinational: output frame presented this cycle
//   audio_in           packed signed input frame, channel 0 in the low slice
//   audio_out          packed signed output frame, registered
//
// Build option: define AUDIO_FX_SOFT_MUTE_EN for a one-step-per-frame gain
// ramp on mute/unmute; otherwise the gain switches hard between 0 and unity.

module audio_fx_pipe #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2,
  parameter int GAIN_W = 9
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic [9:0]               SW,
  input  logic                     audio_in_available,
  input  logic                     audio_out_allowed,
  output logic                     read_audio_in,
  output logic                     write_audio_out,
  input  logic [NUM_CH*DATA_W-1:0] audio_in,
  output logic [NUM_CH*DATA_W-1:0] audio_out
);

  localparam logic [GAIN_W-1:0] UNITY  = {1'b1, {(GAIN_W-1){1'b0}}};
  localparam int                PROD_W = DATA_W + GAIN_W + 1;

  logic                     v1;
  logic                     v2;
  logic                     s1_adv;
  logic                     s2_adv;
  logic [NUM_CH*DATA_W-1:0] s1_data;
  logic [NUM_CH*DATA_W-1:0] s1_next;
  logic [NUM_CH*DATA_W-1:0] s2_next;
  logic [GAIN_W-1:0]        s1_gain;
  logic [GAIN_W-1:0]        gain_now;
  logic                     mute;
  logic [2:0]               shift;
  logic                     unused_sw;

  assign mute      = SW[0];
  assign shift     = SW[3:1];
  assign unused_sw = ^SW[9:4];

  // Handshakes: a stage may take new data when it is empty or being emptied.
  // read is also held low while reset is asserted so it falls with v1/v2.
  assign write_audio_out = v2 & audio_out_allowed;
  assign s2_adv          = ~v2 | write_audio_out;
  assign s1_adv          = ~v1 | s2_adv;
  assign read_audio_in   = resetn & audio_in_available & s1_adv;

`ifdef AUDIO_FX_SOFT_MUTE_EN
  logic [GAIN_W-1:0] gain;

  assign gain_now = gain;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      gain <= UNITY;
    end else if (read_audio_in) begin
      if (mute) begin
        if (gain != '0) gain <= gain - GAIN_W'(1);
      end else begin
        if (gain != UNITY) gain <= gain + GAIN_W'(1);
      end
    end
  end
`else
  assign gain_now = mute ? '0 : UNITY;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] s1_ch;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic        [GAIN_W+1:0] top;
    logic        [DATA_W-1:0] sat;

    assign x_in  = audio_in[ch*DATA_W +: DATA_W];
    assign s1_next[ch*DATA_W +: DATA_W] = x_in >>> shift;

    // Gain is unsigned; a zero MSB makes it a non-negative signed operand.
    assign s1_ch  = s1_data[ch*DATA_W +: DATA_W];
    assign prod   = s1_ch * $signed({1'b0, s1_gain});
    assign scaled = prod >>> (GAIN_W - 1);

    // Result fits in DATA_W iff all bits from the DATA_W sign bit up agree.
    assign top = scaled[PROD_W-1:DATA_W-1];
    assign sat = (top == '0 || top == '1) ? scaled[DATA_W-1:0]
               : scaled[PROD_W-1]         ? {1'b1, {(DATA_W-1){1'b0}}}
               :                            {1'b0, {(DATA_W-1){1'b1}}};
    assign s2_next[ch*DATA_W +: DATA_W] = sat;
  end

  // S1 carries the gain sampled at read time with its frame, so a gain
  // update on the same read edge only affects later frames.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s1_data   <= '0;
      s1_gain   <= UNITY;
      audio_out <= '0;
    end else begin
      if (s1_adv) begin
        v1 <= read_audio_in;
        if (read_audio_in) begin
          s1_data <= s1_next;
          s1_gain <= gain_now;
        end
      end
      if (s2_adv) begin
        v2 <= v1;
        if (v1) audio_out <= s2_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_fx_pipe.sv
`timescale 1ns/1ps
module tb_audio_fx_pipe;

  localparam int DW    = 32;
  localparam int NC    = 2;
  localparam int GW    = 9;
  localparam int FW    = NC * DW;
  localparam int UNITY = 256;

  logic          CLOCK_50 = 1'b0;
  logic          resetn   = 1'b1;
  logic [9:0]    SW       = '0;
  logic          avail    = 1'b0;
  logic          allowed  = 1'b0;
  logic          rd;
  logic          wr;
  logic [FW-1:0] din      = '0;
  logic [FW-1:0] dout;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_fx_pipe #(.DATA_W(DW), .NUM_CH(NC), .GAIN_W(GW)) dut (
    .CLOCK_50          (CLOCK_50),
    .resetn            (resetn),
    .SW                (SW),
    .audio_in_available(avail),
    .audio_out_allowed (allowed),
    .read_audio_in     (rd),
    .write_audio_out   (wr),
    .audio_in          (din),
    .audio_out         (dout)
  );

  // Reference model: frames in flight with the cycle they were read.
  // A frame can be written from read cycle + 2 onward, in order; the
  // pipeline holds at most two frames.
  typedef struct { logic [FW-1:0] data; int rc; } frame_t;
  typedef struct { logic [9:0] sw; logic [31:0] l, r, el, er; } vec_t;

  frame_t        mq[$];
  logic [FW-1:0] tq[$];
  logic [31:0]   obs[$];
  vec_t          tbl[5];
  int            cyc    = 0;
  int            n_cmp  = 0;
  int            n_bad  = 0;
  int            g_ramp = UNITY;
  logic          last_rd;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int gain_for(input logic m);
`ifdef AUDIO_FX_SOFT_MUTE_EN
    return g_ramp;
`else
    return m ? 0 : UNITY;
`endif
  endfunction

  task automatic gain_update(input logic m);
`ifdef AUDIO_FX_SOFT_MUTE_EN
    if (m) g_ramp = (g_ramp > 0) ? g_ramp - 1 : 0;
    else   g_ramp = (g_ramp < UNITY) ? g_ramp + 1 : UNITY;
`else
    if (m) g_ramp = UNITY;
`endif
  endtask

  function automatic logic [FW-1:0] model_out(input logic [FW-1:0] fin, input int sh, input int g);
    logic [FW-1:0]     r;
    logic signed [31:0] s;
    longint            x, p;
    r = '0;
    for (int ch = 0; ch < NC; ch++) begin
      s = fin[ch*DW +: DW];
      x = s;
      x = x >>> sh;
      p = (x * g) >>> 8;
      if (p > 64'sd2147483647)  p = 64'sd2147483647;
      if (p < -64'sd2147483648) p = -64'sd2147483648;
      r[ch*DW +: DW] = 32'(p);
    end
    return r;
  endfunction

  // One clock cycle: entered at a negedge with inputs already driven.
  task automatic step();
    logic   exp_rd, exp_wr;
    frame_t f;
    #1;
    exp_rd = resetn && avail && (mq.size() < 2 || allowed);
    exp_wr = allowed && (mq.size() > 0) && (cyc >= mq[0].rc + 2);
    check("read_audio_in", FW'(rd), FW'(exp_rd));
    check("write_audio_out", FW'(wr), FW'(exp_wr));
    last_rd = exp_rd;
    if (exp_wr) begin
      f = mq.pop_front();
      check("audio_out", dout, f.data);
      obs.push_back(dout[31:0]);
      if (tq.size() > 0) check("table_out", dout, tq.pop_front());
    end
    if (exp_rd) begin
      f.data = model_out(din, int'(SW[3:1]), gain_for(SW[0]));
      f.rc   = cyc;
      mq.push_back(f);
      gain_update(SW[0]);
    end
    @(posedge CLOCK_50);
    cyc++;
    @(negedge CLOCK_50);
  endtask

  task automatic drain();
    avail   = 1'b0;
    allowed = 1'b1;
    for (int k = 0; k < 10 && mq.size() > 0; k++) step();
    check("drain_empty", FW'(mq.size()), '0);
  endtask

  task automatic stream_const(input logic [9:0] sw, input logic [FW-1:0] d, input int n);
    int got;
    got     = 0;
    SW      = sw;
    din     = d;
    avail   = 1'b1;
    allowed = 1'b1;
    for (int k = 0; k < n + 10 && got < n; k++) begin
      step();
      if (last_rd) got++;
    end
    check("stream_count", FW'(got), FW'(n));
  endtask

  initial begin
    int i, reads, base;

    tbl[0] = '{10'h000, 32'h12345678, 32'h80000000, 32'h12345678, 32'h80000000};
    tbl[1] = '{10'h006, 32'hFFFFFCE0, 32'h00000320, 32'hFFFFFF9C, 32'h00000064};
    tbl[2] = '{10'h00E, 32'h7FFFFFFF, 32'h80000000, 32'h00FFFFFF, 32'hFF000000};
    tbl[3] = '{10'h002, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'h00000001};
    tbl[4] = '{10'h3F0, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 32'h00000001};

    // Reset state, with both handshake inputs high
    avail   = 1'b1;
    allowed = 1'b1;
    #2 resetn = 1'b0;
    @(posedge CLOCK_50);
    #1;
    check("rst_read", FW'(rd), '0);
    check("rst_write", FW'(wr), '0);
    check("rst_audio_out", dout, '0);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // Table vectors streamed back to back
    i = 0;
    for (int k = 0; k < 40 && i < 5; k++) begin
      SW  = tbl[i].sw;
      din = {tbl[i].r, tbl[i].l};
      step();
      if (last_rd) begin
        tq.push_back({tbl[i].er, tbl[i].el});
        i++;
      end
    end
    drain();
    check("table_all_out", FW'(tq.size()), '0);

    // Mute then unmute, 258 frames each of 0x00010000
    obs.delete();
    stream_const(10'h001, {32'h00010000, 32'h00010000}, 258);
    stream_const(10'h000, {32'h00010000, 32'h00010000}, 258);
    drain();
    check("mute_obs_count", FW'(obs.size()), FW'(516));
`ifdef AUDIO_FX_SOFT_MUTE_EN
    check("mute_first",   FW'(obs[0]),   FW'(32'h00010000));
    check("mute_second",  FW'(obs[1]),   FW'(32'h0000FF00));
    check("mute_floor",   FW'(obs[256]), FW'(32'h00000000));
    check("unmute_first", FW'(obs[258]), FW'(32'h00000000));
    check("unmute_step",  FW'(obs[259]), FW'(32'h00000100));
    check("unmute_top",   FW'(obs[514]), FW'(32'h00010000));
`else
    check("mute_first",   FW'(obs[0]),   FW'(32'h00000000));
    check("mute_second",  FW'(obs[1]),   FW'(32'h00000000));
    check("mute_floor",   FW'(obs[256]), FW'(32'h00000000));
    check("unmute_first", FW'(obs[258]), FW'(32'h00010000));
    check("unmute_step",  FW'(obs[259]), FW'(32'h00010000));
    check("unmute_top",   FW'(obs[514]), FW'(32'h00010000));
`endif
    check("unmute_last", FW'(obs[515]), FW'(32'h00010000));

    // Output stall for 5 cycles while input keeps streaming
    base    = obs.size();
    reads   = 0;
    SW      = '0;
    avail   = 1'b1;
    allowed = 1'b0;
    for (int k = 0; k < 5; k++) begin
      din = {$urandom, $urandom};
      step();
      if (last_rd) reads++;
    end
    check("stall_reads", FW'(reads), FW'(2));
    allowed = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din = {$urandom, $urandom};
      step();
      if (last_rd) reads++;
    end
    drain();
    check("stall_no_loss", FW'(obs.size() - base), FW'(reads));

    // Reset with both stages full, mute active
    SW      = 10'h001;
    avail   = 1'b1;
    allowed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din = {$urandom, $urandom};
      step();
    end
    allowed = 1'b1;
    #1;
    check("pre_rst_write", FW'(wr), FW'(1));
    check("pre_rst_read", FW'(rd), FW'(1));
    #4 resetn = 1'b0;
    #1;
    check("async_rst_read", FW'(rd), '0);
    check("async_rst_write", FW'(wr), '0);
    check("async_rst_out", dout, '0);
    mq.delete();
    g_ramp = UNITY;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    base   = obs.size();
    SW     = '0;
    din    = {32'h00C0FFEE, 32'hFEDCBA98};
    step();
    drain();
    check("post_rst_count", FW'(obs.size() - base), FW'(1));
    check("post_rst_unity", FW'(obs[obs.size()-1]), FW'(32'hFEDCBA98));

    // Randomised traffic against the model
    for (int k = 0; k < 1500; k++) begin
      avail   = ($urandom_range(0, 3) != 0);
      allowed = ($urandom_range(0, 2) != 0);
      SW      = 10'($urandom_range(0, 1023));
      if (SW[0] && $urandom_range(0, 1) == 0) SW[0] = 1'b0;
      case ($urandom_range(0, 7))
        0:       din = {32'h80000000, 32'h7FFFFFFF};
        1:       din = {32'h7FFFFFFF, 32'h80000000};
        default: din = {$urandom, $urandom};
      endcase
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/audio_fx_pipe.md
AUDIO_FX_PIPE -- requirements
Module: audio_fx_pipe

Interface
REQ-001 Parameter DATA_W, default 32: signed sample width per channel.
REQ-002 Parameter NUM_CH, default 2: channel count; channel 0 in the low slice of the packed buses.
REQ-003 Parameter GAIN_W, default 9: mute-ramp gain width; unity gain = 2^(GAIN_W-1).
REQ-004 Port: CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-005 Port: resetn  in  1  asynchronous active-low reset.
REQ-006 Port: SW  in  10  controls: SW[0] mute, SW[3:1] attenuation shift 0..7, SW[9:4] unused.
REQ-007 Port: audio_in_available  in  1  codec has an input frame.
REQ-008 Port: audio_out_allowed  in  1  codec can take an output frame.
REQ-009 Port: read_audio_in  out  1  combinational; consume one input frame this cycle.
REQ-010 Port: write_audio_out  out  1  combinational; present one output frame this cycle.
REQ-011 Port: audio_in  in  NUM_CH*DATA_W  packed signed input frame.
REQ-012 Port: audio_out  out  NUM_CH*DATA_W  packed signed output frame, registered.

Function
REQ-013 The block SHALL be a 2-stage pipeline, S1 (attenuate) and S2 (gain/saturate), each with a valid bit.
REQ-014 The block SHALL assert write_audio_out = v2 & audio_out_allowed.
REQ-015 S2 SHALL advance when !v2 | write_audio_out; S1 SHALL advance when !v1 | S2 advances.
REQ-016 The block SHALL assert read_audio_in = audio_in_available & S1 advances.
REQ-017 On read, S1 SHALL load each channel arithmetically right-shifted by SW[3:1], sampled that cycle; v1 SHALL set.
REQ-018 On S2 advance with v1=1, S2 SHALL load (S1 x gain) >>> (GAIN_W-1), saturated to the signed DATA_W range, into audio_out; v2 SHALL set.
REQ-019 On S2 advance with v1=0, v2 SHALL clear; audio_out SHALL hold its value.
REQ-020 Latency SHALL be 2 cycles from read_audio_in to the earliest write_audio_out; sustained throughput SHALL be 1 frame/cycle.
REQ-021 Simultaneous write and new S1 load SHALL lose and duplicate no frame.
REQ-022 With audio_out_allowed low and both stages full, read_audio_in SHALL be 0 and all pipeline state SHALL hold.
REQ-023 gain SHALL update only on cycles where read_audio_in=1: decrement by 1 toward 0 if SW[0]=1, increment by 1 toward unity if SW[0]=0.
REQ-024 gain SHALL saturate at 0 and at unity with no wrap-around.
REQ-025 The frame read on a given cycle SHALL use the gain value before that cycle's update.
REQ-026 At unity gain and shift 0, audio_out SHALL equal the input frame bit-exactly.
REQ-027 Saturation SHALL occur only via attenuation/gain arithmetic; the most negative input passes unchanged at unity.

Reset
REQ-028 On resetn low, v1 and v2 SHALL clear immediately, so read_audio_in and write_audio_out fall within the same cycle.
REQ-029 On resetn low, audio_out and S1 data SHALL clear to 0 and gain SHALL load unity.
REQ-030 Frames in flight when resetn asserts SHALL be discarded and never output.
REQ-031 Reset release SHALL be synchronised externally; the first read SHALL be allowed on the first edge after release.

Configuration
REQ-032 Macro AUDIO_FX_SOFT_MUTE_EN defined: gain SHALL ramp per REQ-023.
REQ-033 Macro AUDIO_FX_SOFT_MUTE_EN undefined: gain SHALL be 0 when SW[0]=1 and unity otherwise, combinationally from SW[0] at the read; no ramp register SHALL exist.

Verification
REQ-034 SW=0, both handshakes high, frames L=0x12345678, R=0x80000000 -> outputs identical, 2 cycles later, one frame/cycle.
REQ-035 SW[3:1]=3, L=-800 -> audio_out L = -100.
REQ-036 Soft mute on, SW[0] set, 256 frames of 0x00010000 -> output decays by 0x100 per frame to 0; clearing SW[0] ramps back to 0x00010000 over 256 frames.
REQ-037 audio_out_allowed low for 5 cycles with input streaming -> read stalls after 2 frames held; resumption outputs every frame in order, none lost or duplicated.
REQ-038 resetn pulsed low mid-stream with v1=v2=1 -> both handshakes fall asynchronously, audio_out=0, gain=unity, no stale frame appears after release.
REQ-039 Soft mute off, SW[0] toggled -> the next read frame outputs 0 or passes unchanged immediately.
